lcd_read_text: RTL and testbench

Reads back both 16-character DDRAM lines from the HD44780-compatible LCD over the 4-bit bus. This is the read-side counterpart of the text sender. The block issues a Set-DDRAM-address command, then performs RS=1/RW=1 data reads, assembling nibble pairs into bytes and packing them into line buffers. It sits beside the sender on the same LCD pins, with top-level arbitration via busy.

---
 rtl/lcd_pkg.sv | 72 +++++++
 rtl/lcd_nibble_io.sv | 144 ++++++++++++++
 rtl/lcd_read_text.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_read_text.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, DDRAM addresses and timing helpers for the LCD read path
//
// Contents:
//   rd_state_e   : states of the line read-back FSM
//   nib_op_e     : nibble transfer direction (write / read)
//   nib_state_e  : states of the single-nibble strobe sequencer
//   DDRAM_LINE1/2: Set-DDRAM-address commands for the two display lines
//   calc_*       : delays in CLK cycles derived from the clock frequency
package lcd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_ADDR_H,
        S_SET_ADDR_L,
        S_ADDR_WAIT,
        S_RD_H,
        S_RD_L,
        S_CHAR_WAIT,
        S_NEXT,
        S_DONE
    } rd_state_e;

    typedef enum logic {
        NIB_WRITE,
        NIB_READ
    } nib_op_e;

    typedef enum logic [2:0] {
        N_IDLE,
        N_SETUP,
        N_EHIGH,
        N_ELOW,
        N_DONE
    } nib_state_e;

    localparam logic [7:0] DDRAM_LINE1 = 8'h80;
    localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

    // Width of every delay counter; covers tADDR at several hundred MHz.
    localparam int DLY_W = 24;

    // A zero-length phase would make the "count reached N-1" compare never
    // match, so every delay is clamped to at least one cycle.
    function automatic int at_least_1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int calc_t1us(input int freq);
        return at_least_1(freq / 1000000);
    endfunction

    function automatic int calc_te(input int freq);
        return calc_t1us(freq);
    endfunction

    function automatic int calc_tel(input int freq);
        return calc_t1us(freq);
    endfunction

    function automatic int calc_tsu(input int freq);
        return at_least_1(calc_t1us(freq) / 5);
    endfunction

    function automatic int calc_taddr(input int freq);
        return 53 * calc_t1us(freq);
    endfunction

    function automatic int calc_tchar(input int freq);
        return 10 * calc_t1us(freq);
    endfunction

endpackage

// File: rtl/lcd_nibble_io.sv
// rtl/lcd_nibble_io.sv - one E-strobed 4-bit transfer (write or read) on the LCD bus
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a transfer (accepted only while idle)
//   op, rs, data  : direction, register select and write nibble for the transfer
//   release_bus   : while idle, return RS/RW/oe/data to 0
//   done          : one-cycle pulse after the E-low recovery time
//   rd_nib        : nibble sampled on the last E-high cycle of a read
//   lcd_d_in      : LCD data bus input
//   lcd_e, lcd_rw, lcd_rs, lcd_d_out, lcd_d_oe : registered pin controls
module lcd_nibble_io
    import lcd_pkg::*;
#(
    parameter int TSU = 10,
    parameter int TE  = 50,
    parameter int TEL = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  nib_op_e    op,
    input  logic       rs,
    input  logic [3:0] data,
    input  logic       release_bus,
    output logic       done,
    output logic [3:0] rd_nib,
    input  logic [3:0] lcd_d_in,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_d_out,
    output logic       lcd_d_oe
);

    localparam logic [DLY_W-1:0] TSU_M1 = DLY_W'(TSU - 1);
    localparam logic [DLY_W-1:0] TE_M1  = DLY_W'(TE - 1);
    localparam logic [DLY_W-1:0] TEL_M1 = DLY_W'(TEL - 1);

    nib_state_e       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic [3:0]       dout_q, dout_d;
    logic [3:0]       nib_q, nib_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= N_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= '0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            nib_q   <= nib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        nib_d   = nib_q;
        unique case (state_q)
            N_IDLE: begin
                if (start) begin
                    // RW and oe flip in the same cycle, so the bus is never
                    // driven while the LCD is allowed to drive it.
                    state_d = N_SETUP;
                    cnt_d   = '0;
                    rs_d    = rs;
                    rw_d    = (op == NIB_READ);
                    oe_d    = (op == NIB_WRITE);
                    dout_d  = (op == NIB_WRITE) ? data : 4'h0;
                end else if (release_bus) begin
                    rs_d   = 1'b0;
                    rw_d   = 1'b0;
                    oe_d   = 1'b0;
                    dout_d = 4'h0;
                end
            end
            N_SETUP: begin
                if (cnt_q == TSU_M1) begin
                    state_d = N_EHIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            N_EHIGH: begin
                if (cnt_q == TE_M1) begin
                    state_d = N_ELOW;
                    cnt_d   = '0;
                    if (rw_q) begin
                        nib_d = lcd_d_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            N_ELOW: begin
                if (cnt_q == TEL_M1) begin
                    state_d = N_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            N_DONE: begin
                state_d = N_IDLE;
            end
            default: begin
                state_d = N_IDLE;
            end
        endcase
        // E is a flop mirroring "in the strobe phase" so the pin cannot
        // glitch on multi-bit state decode.
        e_d = (state_d == N_EHIGH);
    end

    assign done      = (state_q == N_DONE);
    assign rd_nib    = nib_q;
    assign lcd_e     = e_q;
    assign lcd_rw    = rw_q;
    assign lcd_rs    = rs_q;
    assign lcd_d_out = dout_q;
    assign lcd_d_oe  = oe_q;

endmodule

// File: rtl/lcd_read_text.sv
// rtl/lcd_read_text.sv - read both DDRAM text lines back from an HD44780 LCD in 4-bit mode
//
// Ports:
//   CLK, RESET_N       : clock, asynchronous active-low reset
//   readText           : start pulse, honoured only while idle
//   LCD_D_in           : LCD data bus input (D7..D4)
//   LCD_D_out/LCD_D_oe : bus drive value and drive enable
//   LCD_E/LCD_RW/LCD_RS: LCD strobe, read/write, register select
//   line1, line2       : captured characters, char 0 in the top byte
//   busy               : transfer in progress
//   readingDone        : one-cycle pulse when both lines are captured
module lcd_read_text
    import lcd_pkg::*;
#(
    parameter int LINE_LENGTH = 16,
    parameter int FREQ        = 50000000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   readText,
    input  logic [3:0]             LCD_D_in,
    output logic [3:0]             LCD_D_out,
    output logic                   LCD_D_oe,
    output logic                   LCD_E,
    output logic                   LCD_RW,
    output logic                   LCD_RS,
    output logic [8*LINE_LENGTH:1] line1,
    output logic [8*LINE_LENGTH:1] line2,
    output logic                   busy,
    output logic                   readingDone
);

    localparam int LW     = 8 * LINE_LENGTH;
    localparam int T_SU   = calc_tsu(FREQ);
    localparam int T_E    = calc_te(FREQ);
    localparam int T_EL   = calc_tel(FREQ);
    localparam logic [DLY_W-1:0] ADDR_M1 = DLY_W'(calc_taddr(FREQ) - 1);
    localparam logic [DLY_W-1:0] CHAR_M1 = DLY_W'(calc_tchar(FREQ) - 1);
    localparam logic [5:0]       LAST_CHAR = 6'(LINE_LENGTH - 1);

    rd_state_e        state_q, state_d;
    logic             line_sel_q, line_sel_d;
    logic [5:0]       char_idx_q, char_idx_d;
    logic [3:0]       hi_q, hi_d;
    logic [DLY_W-1:0] wait_q, wait_d;
    logic             started_q, started_d;
    logic [LW-1:0]    line1_q, line1_d;
    logic [LW-1:0]    line2_q, line2_d;

    logic       nib_start;
    nib_op_e    nib_op;
    logic       nib_rs;
    logic [3:0] nib_data;
    logic       nib_done;
    logic [3:0] nib_rd;
    logic       bus_release;
    logic [7:0] line_addr;
    logic [7:0] byte_v;

    lcd_nibble_io #(
        .TSU (T_SU),
        .TE  (T_E),
        .TEL (T_EL)
    ) u_nibble_io (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .start       (nib_start),
        .op          (nib_op),
        .rs          (nib_rs),
        .data        (nib_data),
        .release_bus (bus_release),
        .done        (nib_done),
        .rd_nib      (nib_rd),
        .lcd_d_in    (LCD_D_in),
        .lcd_e       (LCD_E),
        .lcd_rw      (LCD_RW),
        .lcd_rs      (LCD_RS),
        .lcd_d_out   (LCD_D_out),
        .lcd_d_oe    (LCD_D_oe)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            line_sel_q <= 1'b0;
            char_idx_q <= '0;
            hi_q       <= '0;
            wait_q     <= '0;
            started_q  <= 1'b0;
            line1_q    <= '0;
            line2_q    <= '0;
        end else begin
            state_q    <= state_d;
            line_sel_q <= line_sel_d;
            char_idx_q <= char_idx_d;
            hi_q       <= hi_d;
            wait_q     <= wait_d;
            started_q  <= started_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_sel_d = line_sel_q;
        char_idx_d = char_idx_q;
        hi_d       = hi_q;
        wait_d     = wait_q;
        started_d  = started_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        nib_start  = 1'b0;
        nib_op     = NIB_WRITE;
        nib_rs     = 1'b0;
        nib_data   = 4'h0;
        line_addr  = line_sel_q ? DDRAM_LINE2 : DDRAM_LINE1;
        byte_v     = {hi_q, nib_rd};

        // Nibble states fire the sequencer once on entry (started_q) and
        // advance on its done pulse.
        unique case (state_q)
            S_IDLE: begin
                if (readText) begin
                    line_sel_d = 1'b0;
                    char_idx_d = '0;
                    state_d    = S_SET_ADDR_H;
                end
            end
            S_SET_ADDR_H, S_SET_ADDR_L: begin
                nib_op    = NIB_WRITE;
                nib_rs    = 1'b0;
                nib_data  = (state_q == S_SET_ADDR_H) ? line_addr[7:4] : line_addr[3:0];
                nib_start = !started_q;
                if (nib_done) begin
                    started_d = 1'b0;
                    wait_d    = '0;
                    state_d   = (state_q == S_SET_ADDR_H) ? S_SET_ADDR_L : S_ADDR_WAIT;
                end else begin
                    started_d = 1'b1;
                end
            end
            S_ADDR_WAIT: begin
                if (wait_q == ADDR_M1) begin
                    wait_d  = '0;
                    state_d = S_RD_H;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RD_H, S_RD_L: begin
                nib_op    = NIB_READ;
                nib_rs    = 1'b1;
                nib_start = !started_q;
                if (nib_done) begin
                    started_d = 1'b0;
                    wait_d    = '0;
                    if (state_q == S_RD_H) begin
                        hi_d    = nib_rd;
                        state_d = S_RD_L;
                    end else begin
                        // Constant-index lanes: only the addressed byte moves.
                        for (int i = 0; i < LINE_LENGTH; i++) begin
                            if (char_idx_q == 6'(i)) begin
                                if (line_sel_q) begin
                                    line2_d[8*(LINE_LENGTH-i)-1 -: 8] = byte_v;
                                end else begin
                                    line1_d[8*(LINE_LENGTH-i)-1 -: 8] = byte_v;
                                end
                            end
                        end
                        state_d = S_CHAR_WAIT;
                    end
                end else begin
                    started_d = 1'b1;
                end
            end
            S_CHAR_WAIT: begin
                if (wait_q == CHAR_M1) begin
                    wait_d  = '0;
                    state_d = S_NEXT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (char_idx_q < LAST_CHAR) begin
                    char_idx_d = char_idx_q + 1'b1;
                    state_d    = S_RD_H;
                end else if (!line_sel_q) begin
                    line_sel_d = 1'b1;
                    char_idx_d = '0;
                    state_d    = S_SET_ADDR_H;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clearing the pins on the way into DONE makes them low during the
        // readingDone cycle itself.
        bus_release = (state_d == S_DONE);
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign readingDone = (state_q == S_DONE);
    assign line1       = line1_q;
    assign line2       = line2_q;

endmodule

// File: tb/tb_lcd_read_text.sv
// tb/tb_lcd_read_text.sv - self-checking bench for lcd_read_text with a behavioural LCD model
module tb_lcd_read_text;

    localparam int L       = 16;
    localparam int FREQ    = 50000000;
    localparam int T1US    = FREQ / 1000000;
    localparam int TSU     = T1US / 5;
    localparam int TE      = T1US;
    localparam int TADDR   = 53 * T1US;
    localparam int TCHAR   = 10 * T1US;
    localparam int TIMEOUT = 40000;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         readText = 1'b0;
    logic [3:0]   LCD_D_in = 4'h0;
    logic [3:0]   LCD_D_out;
    logic         LCD_D_oe, LCD_E, LCD_RW, LCD_RS;
    logic [8*L:1] line1, line2;
    logic         busy, readingDone;

    always #10 CLK = ~CLK;

    lcd_read_text #(.LINE_LENGTH(L), .FREQ(FREQ)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .readText    (readText),
        .LCD_D_in    (LCD_D_in),
        .LCD_D_out   (LCD_D_out),
        .LCD_D_oe    (LCD_D_oe),
        .LCD_E       (LCD_E),
        .LCD_RW      (LCD_RW),
        .LCD_RS      (LCD_RS),
        .line1       (line1),
        .line2       (line2),
        .busy        (busy),
        .readingDone (readingDone)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- LCD model: DDRAM plus address counter ----------------
    logic [7:0] ddram [0:127];
    logic [6:0] lcd_addr = 7'd0;
    logic       lcd_ph   = 1'b0;
    logic [3:0] lcd_hi   = 4'h0;

    always @(posedge LCD_E) begin
        if (LCD_RW) LCD_D_in = lcd_ph ? ddram[lcd_addr][3:0] : ddram[lcd_addr][7:4];
    end

    always @(negedge LCD_E or negedge RESET_N) begin
        if (!RESET_N) begin
            lcd_ph = 1'b0;
        end else begin
            if (!LCD_RW) begin
                if (!lcd_ph) lcd_hi = LCD_D_out;
                else if (!LCD_RS && lcd_hi[3]) lcd_addr = {lcd_hi[2:0], LCD_D_out};
            end else if (lcd_ph) begin
                lcd_addr = lcd_addr + 7'd1;
            end
            lcd_ph = ~lcd_ph;
        end
    end

    // ---------------- bus monitor (samples on the falling CLK edge) ----------------
    int clr_gen = 0, clr_seen = 0;
    int cyc = 0, last_chg = 0, rise_cyc = 0, fall_cyc = 0;
    int mon_ph = 0, last_kind = 0;
    int done_cnt, wr_cnt, rd_cnt, wr_rs_bad, rd_bad, oe_rw_bad, setup_bad, hold_bad, ew_bad;
    int min_addr_gap, min_char_gap;
    logic [15:0] wr_seq;
    logic        busy_at_done;
    logic        e_p = 1'b0;
    logic [2:0]  ctl_p = 3'b0;

    always @(negedge CLK) begin
        cyc++;
        if (clr_seen != clr_gen) begin
            clr_seen = clr_gen;
            done_cnt = 0; wr_cnt = 0; rd_cnt = 0; wr_rs_bad = 0; rd_bad = 0;
            oe_rw_bad = 0; setup_bad = 0; hold_bad = 0; ew_bad = 0;
            min_addr_gap = 1000000; min_char_gap = 1000000;
            wr_seq = 16'h0; busy_at_done = 1'b1;
        end
        if (!RESET_N) begin
            mon_ph = 0;
            last_kind = 0;
        end else begin
            if ({LCD_RS, LCD_RW, LCD_D_oe} != ctl_p) begin
                if (LCD_E) hold_bad++;
                last_chg = cyc;
            end
            if (LCD_D_oe && LCD_RW) oe_rw_bad++;
            if (readingDone) begin
                done_cnt++;
                busy_at_done = busy;
            end
            if (LCD_E && !e_p) begin
                if (cyc - last_chg < TSU) setup_bad++;
                if (last_kind == 1 && cyc - fall_cyc < min_addr_gap) min_addr_gap = cyc - fall_cyc;
                if (last_kind == 2 && cyc - fall_cyc < min_char_gap) min_char_gap = cyc - fall_cyc;
                last_kind = 0;
                rise_cyc = cyc;
            end
            if (!LCD_E && e_p) begin
                if (cyc - rise_cyc != TE) ew_bad++;
                fall_cyc = cyc;
                if (LCD_RW) begin
                    rd_cnt++;
                    if (LCD_D_oe) rd_bad++;
                    last_kind = (mon_ph == 1) ? 2 : 0;
                end else begin
                    wr_cnt++;
                    wr_seq = {wr_seq[11:0], LCD_D_out};
                    if (LCD_RS) wr_rs_bad++;
                    last_kind = (mon_ph == 1) ? 1 : 0;
                end
                mon_ph = 1 - mon_ph;
            end
        end
        e_p   = LCD_E;
        ctl_p = {LCD_RS, LCD_RW, LCD_D_oe};
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic mon_clear();
        clr_gen++;
        tick();
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_str(input int base, input string s);
        for (int i = 0; i < L; i++) ddram[base + i] = s[i];
    endtask

    task automatic pulse_read();
        @(posedge CLK);
        #1 readText = 1'b1;
        @(posedge CLK);
        #1 readText = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int k);
        int n = 0;
        while (rd_cnt < k && n < TIMEOUT) begin
            tick();
            n++;
        end
        check_eq({tag, "_reach_char"}, 128'(rd_cnt >= k), 128'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!readingDone && n < TIMEOUT) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_in_time"}, 128'(n < TIMEOUT), 128'd1);
        repeat (60) tick();
    endtask

    task automatic check_read(input string tag, input logic [127:0] e1, input logic [127:0] e2);
        check_eq({tag, "_line1"}, line1, e1);
        check_eq({tag, "_line2"}, line2, e2);
        check_eq({tag, "_done_pulses"}, 128'(done_cnt), 128'd1);
        check_eq({tag, "_busy_at_done"}, 128'(busy_at_done), 128'd0);
        check_eq({tag, "_busy_after"}, 128'(busy), 128'd0);
        check_eq({tag, "_wr_count"}, 128'(wr_cnt), 128'd4);
        check_eq({tag, "_wr_nibbles"}, 128'(wr_seq), 128'h80C0);
        check_eq({tag, "_wr_rs"}, 128'(wr_rs_bad), 128'd0);
        check_eq({tag, "_rd_count"}, 128'(rd_cnt), 128'(4 * L));
        check_eq({tag, "_rd_oe"}, 128'(rd_bad), 128'd0);
        check_eq({tag, "_oe_rw_overlap"}, 128'(oe_rw_bad), 128'd0);
        check_eq({tag, "_setup"}, 128'(setup_bad), 128'd0);
        check_eq({tag, "_ctl_during_e"}, 128'(hold_bad), 128'd0);
        check_eq({tag, "_e_width"}, 128'(ew_bad), 128'd0);
        check_eq({tag, "_addr_gap_ok"}, 128'(min_addr_gap >= TADDR), 128'd1);
        check_eq({tag, "_char_gap_ok"}, 128'(min_char_gap >= TCHAR), 128'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [127:0] exp1, exp2;
    logic [7:0]   b;

    initial begin
        RESET_N = 1'b0;
        repeat (4) tick();
        check_eq("reset_pins", 128'({LCD_E, LCD_RW, LCD_RS, LCD_D_oe, LCD_D_out, busy, readingDone}), 128'd0);
        check_eq("reset_line1", line1, 128'd0);
        check_eq("reset_line2", line2, 128'd0);
        RESET_N = 1'b1;
        mon_clear();

        // Read 1: known strings, with a second readText during char 5 of line 1.
        fill_random();
        load_str(8'h00, "HELLO WORLD 1234");
        load_str(8'h40, "FPGA LCD READ OK");
        exp1 = "HELLO WORLD 1234";
        exp2 = "FPGA LCD READ OK";
        pulse_read();
        wait_rd("repulse", 10);
        check_eq("repulse_busy", 128'(busy), 128'd1);
        pulse_read();
        wait_done("read1");
        check_read("read1", exp1, exp2);

        // Read 2: aborted by reset during the low nibble of line 2 char 7.
        mon_clear();
        fill_random();
        pulse_read();
        wait_rd("abort", 2 * (L + 7) + 1);
        begin
            int n = 0;
            while (!LCD_E && n < TIMEOUT) begin
                tick();
                n++;
            end
            check_eq("abort_e_high", 128'(LCD_E), 128'd1);
        end
        #3 RESET_N = 1'b0;
        #1;
        check_eq("abort_pins", 128'({LCD_E, LCD_RW, LCD_RS, LCD_D_oe, LCD_D_out, busy, readingDone}), 128'd0);
        check_eq("abort_line1", line1, 128'd0);
        check_eq("abort_line2", line2, 128'd0);
        readText = 1'b1;
        repeat (3) tick();
        readText = 1'b0;
        RESET_N = 1'b1;
        repeat (5) tick();
        check_eq("reset_wins_busy", 128'(busy), 128'd0);

        // Read 3: alternating 0xFF/0x00 on line 1, random bytes on line 2.
        mon_clear();
        fill_random();
        exp1 = '0;
        exp2 = '0;
        for (int i = 0; i < L; i++) begin
            b = (i % 2 == 0) ? 8'hFF : 8'h00;
            ddram[i] = b;
            exp1 = {exp1[119:0], b};
            b = 8'($urandom_range(0, 255));
            ddram[8'h40 + i] = b;
            exp2 = {exp2[119:0], b};
        end
        pulse_read();
        wait_done("read3");
        check_read("read3", exp1, exp2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
